// File: rtl/fp_norm_round_if.sv
// Handshake bundle between the FP adder's mantissa-add stage, the normalise/round
// stage and its consumer: an input sum channel and a packed result channel.
interface fp_norm_round_if #(
   parameter int EXP_W = 10
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sign;
   logic signed [EXP_W-1:0] in_exp;
   logic [27:0]             in_man;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             out_result;
   logic [2:0]              out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_man, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_man, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_norm_round.sv
// Post-add normalise / round-to-nearest-even / pack stage for single precision.
// Multi-cycle FSM: IDLE -> NORM (one shift step per cycle) -> ROUND -> PACK -> DONE.
module fp_norm_round #(
   parameter int EXP_W      = 10,
   parameter int NORM_SHIFT = 1
) (
   input  logic              clk,
   input  logic              reset,
   fp_norm_round_if.slave    bus,
   output logic              busy
);

   localparam int XW = EXP_W + 1;
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX  = XW'(255);

   typedef enum logic [2:0] {
      IDLE,
      NORM,
      ROUND,
      PACK,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   // One extra exponent bit so carry and round increments never wrap.
   logic                 sign_q;
   logic signed [XW-1:0] exp_q;
   logic [27:0]          man_q;
   logic                 inexact_q;

   logic                 norm_zero;
   logic                 norm_flush;
   logic [2:0]           shift_k;
   logic signed [XW-1:0] shift_ext;
   logic                 rnd_inc;
   logic [24:0]          rnd_sum;

   always_comb begin
      norm_zero  = (man_q == 28'd0);
      norm_flush = !norm_zero && (exp_q <= EXP_ZERO);
   end

   // Shift this step by the distance to the leading one, capped at NORM_SHIFT.
   always_comb begin
      shift_k = 3'(NORM_SHIFT);
      for (int i = NORM_SHIFT; i >= 1; i--) begin
         if (man_q[26-i]) shift_k = 3'(i);
      end
      shift_ext = $signed({{(XW-3){1'b0}}, shift_k});
   end

   always_comb begin
      rnd_inc = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
      rnd_sum = man_q[27:3] + {24'd0, rnd_inc};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = NORM;
         NORM: begin
            if (norm_zero || norm_flush)      state_nx = DONE;
            else if (man_q[27] || man_q[26])  state_nx = ROUND;
         end
         ROUND:   state_nx = PACK;
         PACK:    state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: in_ready is gated by reset combinationally so nothing is accepted on
   // the edge where reset is released, even though state already reads IDLE.
   assign bus.in_ready  = (state == IDLE) && !reset;
   assign bus.out_valid = (state == DONE);
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sign_q         <= 1'b0;
         exp_q          <= '0;
         man_q          <= '0;
         inexact_q      <= 1'b0;
         bus.out_result <= '0;
         bus.out_flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign_q    <= bus.in_sign;
                  exp_q     <= {bus.in_exp[EXP_W-1], bus.in_exp};
                  man_q     <= bus.in_man;
                  inexact_q <= 1'b0;
               end
            end
            NORM: begin
               if (norm_zero) begin
                  bus.out_result <= {sign_q, 31'd0};
                  bus.out_flags  <= 3'b000;
               end else if (norm_flush) begin
                  bus.out_result <= {sign_q, 31'd0};
                  bus.out_flags  <= 3'b011;
               end else if (man_q[27]) begin
                  // Bit shifted out of R folds into sticky.
                  man_q <= {1'b0, man_q[27:2], man_q[1] | man_q[0]};
                  exp_q <= exp_q + EXP_ONE;
               end else if (!man_q[26]) begin
                  man_q <= man_q << shift_k;
                  exp_q <= exp_q - shift_ext;
               end
            end
            ROUND: begin
               inexact_q <= |man_q[2:0];
               if (rnd_sum[24]) begin
                  man_q <= {1'b0, rnd_sum[24:1], 3'b000};
                  exp_q <= exp_q + EXP_ONE;
               end else begin
                  man_q <= {rnd_sum, 3'b000};
               end
            end
            PACK: begin
               if (exp_q >= EXP_MAX) begin
                  bus.out_result <= {sign_q, 8'hFF, 23'd0};
                  bus.out_flags  <= 3'b101;
               end else begin
                  bus.out_result <= {sign_q, exp_q[7:0], man_q[25:3]};
                  bus.out_flags  <= {2'b00, inexact_q};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
